// File: rtl/axi_burst_read_master.sv
// AXI4 read master: splits one host request into INCR bursts (capped length, never crossing 4KB)
// and streams the read data out. Define AXI_RD_RLAST_CHECK_EN to flag RLAST mismatches in ERROR.
module axi_burst_read_master #(
  parameter int C_M_AXI_BURST_LEN    = 256,
  parameter int C_M_AXI_ID_WIDTH     = 1,
  parameter int C_M_AXI_ADDR_WIDTH   = 32,
  parameter int C_M_AXI_DATA_WIDTH   = 16,
  parameter int C_M_AXI_ARUSER_WIDTH = 1,
  parameter int C_M_AXI_RUSER_WIDTH  = 1,
  parameter int C_XFER_LEN_WIDTH     = 16
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESET,
  input  logic                            INIT_AXI_TXN,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   START_ADDR,
  input  logic [C_XFER_LEN_WIDTH-1:0]     XFER_BEATS,
  output logic                            TXN_DONE,
  output logic                            ERROR,
  output logic                            BUSY,
  output logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_ARID,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [7:0]                      M_AXI_ARLEN,
  output logic [2:0]                      M_AXI_ARSIZE,
  output logic [1:0]                      M_AXI_ARBURST,
  output logic                            M_AXI_ARLOCK,
  output logic [3:0]                      M_AXI_ARCACHE,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic [3:0]                      M_AXI_ARQOS,
  output logic [C_M_AXI_ARUSER_WIDTH-1:0] M_AXI_ARUSER,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_RID,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RLAST,
  input  logic [C_M_AXI_RUSER_WIDTH-1:0]  M_AXI_RUSER,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   DOUT_DATA,
  output logic                            DOUT_VALID,
  output logic                            DOUT_LAST,
  input  logic                            DOUT_READY
);

  localparam int BYTES = C_M_AXI_DATA_WIDTH / 8;
  localparam int SIZE  = $clog2(BYTES);
  localparam int CW    = ((C_XFER_LEN_WIDTH > 13) ? C_XFER_LEN_WIDTH : 13) + 1;

  // state | meaning
  // IDLE  | wait for start edge ; CALC | size next burst ; ADDR | issue AR
  // DATA  | forward burst beats ; DONE | one-cycle completion pulse
  typedef enum logic [2:0] {S_IDLE, S_CALC, S_ADDR, S_DATA, S_DONE} state_t;
  state_t state, state_nxt;

  logic                          init_q;
  logic                          start_edge;
  logic [C_M_AXI_ADDR_WIDTH-1:0] addr;
  logic [C_XFER_LEN_WIDTH-1:0]   remaining;
  logic [8:0]                    burst_beats;
  logic [8:0]                    burst_left;
  logic [7:0]                    arlen;
  logic                          error;
  logic                          arvalid, rready, dout_valid, txn_done, busy;
  logic                          beat, burst_end;
  logic [12:0]                   to_boundary;
  logic [CW-1:0]                 rem_ext, cap_ext, bnd_ext, beats_calc;

  assign start_edge = INIT_AXI_TXN & ~init_q;
  assign beat       = M_AXI_RVALID & rready;
  assign burst_end  = beat && (burst_left == 9'd1);

  // Burst size: smallest of what is left, the burst cap and the room before the next 4KB page.
  always_comb begin
    to_boundary = 13'h1000 - {1'b0, addr[11:0]};
    rem_ext     = CW'(remaining);
    cap_ext     = CW'(C_M_AXI_BURST_LEN);
    bnd_ext     = CW'(to_boundary >> SIZE);
    beats_calc  = rem_ext;
    if (cap_ext < beats_calc) beats_calc = cap_ext;
    if (bnd_ext < beats_calc) beats_calc = bnd_ext;
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) state <= S_IDLE;
    else              state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    arvalid    = 1'b0;
    rready     = 1'b0;
    dout_valid = 1'b0;
    txn_done   = 1'b0;
    busy       = 1'b1;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start_edge) state_nxt = S_CALC;
      end
      S_CALC: state_nxt = (remaining == '0) ? S_DONE : S_ADDR;
      S_ADDR: begin
        arvalid = 1'b1;
        if (M_AXI_ARREADY) state_nxt = S_DATA;
      end
      S_DATA: begin
        rready     = DOUT_READY;
        dout_valid = M_AXI_RVALID;
        if (burst_end)
          state_nxt = (remaining != C_XFER_LEN_WIDTH'(1)) ? S_CALC : S_DONE;
      end
      S_DONE: begin
        txn_done  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      init_q      <= 1'b0;
      addr        <= '0;
      remaining   <= '0;
      burst_beats <= '0;
      burst_left  <= '0;
      arlen       <= '0;
      error       <= 1'b0;
    end else begin
      init_q <= INIT_AXI_TXN;
      case (state)
        S_IDLE: begin
          if (start_edge) begin
            addr      <= START_ADDR & ~C_M_AXI_ADDR_WIDTH'(BYTES - 1);
            remaining <= XFER_BEATS;
            error     <= 1'b0;
          end
        end
        S_CALC: begin
          burst_beats <= 9'(beats_calc);
          burst_left  <= 9'(beats_calc);
          if (remaining != '0) arlen <= 8'(beats_calc - CW'(1));
        end
        S_DATA: begin
          if (beat) begin
            burst_left <= burst_left - 9'd1;
            remaining  <= remaining - C_XFER_LEN_WIDTH'(1);
            if (M_AXI_RRESP[1]) error <= 1'b1;
`ifdef AXI_RD_RLAST_CHECK_EN
            if (M_AXI_RLAST != (burst_left == 9'd1)) error <= 1'b1;
`endif
            if (burst_end)
              addr <= addr + (C_M_AXI_ADDR_WIDTH'(burst_beats) << SIZE);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef AXI_RD_RLAST_CHECK_EN
  logic unused_inputs;
  assign unused_inputs = ^{M_AXI_RID, M_AXI_RUSER, M_AXI_RRESP[0]};
`else
  logic unused_inputs;
  assign unused_inputs = ^{M_AXI_RID, M_AXI_RUSER, M_AXI_RRESP[0], M_AXI_RLAST};
`endif

  assign TXN_DONE      = txn_done;
  assign ERROR         = error;
  assign BUSY          = busy;
  assign M_AXI_ARID    = '0;
  assign M_AXI_ARADDR  = addr;
  assign M_AXI_ARLEN   = arlen;
  assign M_AXI_ARSIZE  = 3'(SIZE);
  assign M_AXI_ARBURST = 2'b01;
  assign M_AXI_ARLOCK  = 1'b0;
  assign M_AXI_ARCACHE = 4'b0011;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARQOS   = 4'b0000;
  assign M_AXI_ARUSER  = '0;
  assign M_AXI_ARVALID = arvalid;
  assign M_AXI_RREADY  = rready;
  assign DOUT_DATA     = M_AXI_RDATA;
  assign DOUT_VALID    = dout_valid;
  assign DOUT_LAST     = (state == S_DATA) && (burst_left == 9'd1) &&
                         (remaining == C_XFER_LEN_WIDTH'(1));

endmodule

// File: tb/tb_axi_burst_read_master.sv
// Bench for axi_burst_read_master: reactive AXI slave, burst/stream monitor and a
// page/cap-splitting reference model computed from start address and beat count.
module tb_axi_burst_read_master;
  localparam int AW = 32;
  localparam int DW = 16;
  localparam int XW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, init;
  logic [AW-1:0] start_addr;
  logic [XW-1:0] xfer_beats;
  logic          txn_done, error, busy;
  logic [0:0]    arid, aruser, rid, ruser;
  logic [AW-1:0] araddr;
  logic [7:0]    arlen;
  logic [2:0]    arsize, arprot;
  logic [1:0]    arburst, rresp;
  logic          arlock, arvalid, arready;
  logic [3:0]    arcache, arqos;
  logic [DW-1:0] rdata, dout_data;
  logic          rlast, rvalid, rready, dout_valid, dout_last, dout_ready;

  axi_burst_read_master dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESET(rst), .INIT_AXI_TXN(init),
    .START_ADDR(start_addr), .XFER_BEATS(xfer_beats),
    .TXN_DONE(txn_done), .ERROR(error), .BUSY(busy),
    .M_AXI_ARID(arid), .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize),
    .M_AXI_ARBURST(arburst), .M_AXI_ARLOCK(arlock), .M_AXI_ARCACHE(arcache),
    .M_AXI_ARPROT(arprot), .M_AXI_ARQOS(arqos), .M_AXI_ARUSER(aruser),
    .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RID(rid), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RLAST(rlast),
    .M_AXI_RUSER(ruser), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready),
    .DOUT_DATA(dout_data), .DOUT_VALID(dout_valid), .DOUT_LAST(dout_last),
    .DOUT_READY(dout_ready)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // slave configuration and state
  int ar_delay = 0, rmode = 0, err_beat = -1, rlast_beat = -1;
  bit s_active = 0, prev_pend = 0;
  logic [AW-1:0] s_word = '0, prev_addr = '0;
  logic [7:0] prev_len = '0;
  int s_left = 0, beat_no = 0, ar_wait = 0;

  // monitor records
  logic [AW-1:0] got_ar_addr[$];
  logic [7:0]    got_ar_len[$];
  logic [DW-1:0] got_data[$];
  logic          got_last[$];
  logic          got_err[$];
  int done_cnt, done_cyc, start_cyc, ar_unstable, arv_cycles, valid_bad, rready_bad;
  logic busy_at_done;

  // reference model
  logic [AW-1:0] exp_ar_addr[$];
  logic [7:0]    exp_ar_len[$];
  logic [DW-1:0] exp_data[$];

  initial begin : slave
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0;
    rid = '0; ruser = '0; dout_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        s_active = 0; prev_pend = 0; ar_wait = 0;
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
      end else begin
        arready = arvalid && !s_active && (ar_wait >= ar_delay);
        rvalid  = s_active;
        rdata   = DW'(s_word);
        rresp   = (s_active && beat_no == err_beat) ? 2'b10 : 2'b00;
        rlast   = s_active && ((rlast_beat >= 0) ? (beat_no == rlast_beat) : (s_left == 1));
        case (rmode)
          1:       dout_ready = ~dout_ready;
          2:       dout_ready = 1'($urandom_range(0, 1));
          default: dout_ready = 1'b1;
        endcase
        #1;
        if (prev_pend && (!arvalid || araddr !== prev_addr || arlen !== prev_len)) ar_unstable++;
        if (arvalid) arv_cycles++;
        if (arvalid && !arready) begin
          prev_pend = 1; prev_addr = araddr; prev_len = arlen; ar_wait++;
        end else begin
          prev_pend = 0; ar_wait = 0;
        end
        if (dout_valid !== rvalid) valid_bad++;
        if (rvalid && rready !== dout_ready) rready_bad++;
        if (arvalid && arready) begin
          got_ar_addr.push_back(araddr); got_ar_len.push_back(arlen);
          s_active = 1; s_word = araddr >> 1; s_left = int'(arlen) + 1;
        end
        if (rvalid && rready) begin
          got_data.push_back(dout_data); got_last.push_back(dout_last); got_err.push_back(error);
          s_word++; s_left--; beat_no++;
          if (s_left == 0) s_active = 0;
        end
        if (txn_done) begin
          done_cnt++; done_cyc = cyc; busy_at_done = busy;
        end
      end
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation still running, want finished");
    $fatal(1, "watchdog");
  end

  task automatic clear_mon();
    got_ar_addr.delete(); got_ar_len.delete(); got_data.delete(); got_last.delete();
    got_err.delete();
    done_cnt = 0; done_cyc = 0; ar_unstable = 0; arv_cycles = 0; valid_bad = 0;
    rready_bad = 0; beat_no = 0; busy_at_done = 1'b0;
  endtask

  task automatic build_model(input logic [AW-1:0] a, input int n);
    logic [AW-1:0] cur;
    int rem, room, b;
    exp_ar_addr.delete(); exp_ar_len.delete(); exp_data.delete();
    cur = a & ~32'h1;
    rem = n;
    while (rem > 0) begin
      room = (4096 - int'(cur[11:0])) / 2;
      b = (rem > 256) ? 256 : rem;
      if (room < b) b = room;
      exp_ar_addr.push_back(cur);
      exp_ar_len.push_back(8'(b - 1));
      cur  = cur + AW'(b * 2);
      rem -= b;
    end
    for (int i = 0; i < n; i++) exp_data.push_back(DW'((a >> 1) + AW'(i)));
  endtask

  task automatic run_xfer(input logic [AW-1:0] a, input int n, input bit glitch,
                          output bit timed_out);
    clear_mon();
    @(negedge clk);
    start_addr = a; xfer_beats = XW'(n); init = 1'b1; start_cyc = cyc;
    timed_out = 1'b1;
    for (int k = 0; k < 4 * n + 100; k++) begin
      @(negedge clk); #2;
      if (glitch && k == 10) init = 1'b0;
      if (glitch && k == 11) init = 1'b1;
      if (done_cnt > 0) begin timed_out = 1'b0; break; end
    end
    repeat (4) @(negedge clk);
    init = 1'b0;
    repeat (2) @(negedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b1; init = 1'b0; start_addr = '0; xfer_beats = '0;
    repeat (3) @(negedge clk);
    #2;
    n_cmp++;
    if ({arvalid, rready, txn_done, error, busy, dout_valid} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b want 000000", {arvalid, rready, txn_done, error, busy, dout_valid});
    end
    n_cmp++;
    if (araddr !== '0 || arlen !== '0) begin
      n_bad++; $display("FAIL reset_ar: got addr %h len %0d want 0/0", araddr, arlen);
    end
    n_cmp++;
    if ({arid, arsize, arburst, arlock, arcache, arprot, arqos, aruser} !==
        {1'b0, 3'd1, 2'b01, 1'b0, 4'b0011, 3'd0, 4'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL ar_constants: got size %0d burst %b cache %b want 1/01/0011", arsize, arburst, arcache);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_split();
    logic [AW-1:0] ta[$];
    int tn[$];
    bit to;
    ta = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0FF0};
    tn = '{256, 600, 16};
    for (int i = 0; i < 5; i++) begin
      if (i % 2 == 0) ta.push_back($urandom);
      else ta.push_back(($urandom & 32'hFFFF_F000) | ((32'h1000 - 32'($urandom_range(1, 600))) & 32'hFFF));
      tn.push_back($urandom_range(1, 700));
    end
    for (int t = 0; t < ta.size(); t++) begin
      rmode = (t < 3) ? 0 : 2;
      build_model(ta[t], tn[t]);
      run_xfer(ta[t], tn[t], 1'b0, to);
      n_cmp++;
      if (to) begin n_bad++; $display("FAIL split_timeout[%0d]: got no TXN_DONE want TXN_DONE", t); end
      n_cmp++;
      if (got_ar_addr.size() != exp_ar_addr.size()) begin
        n_bad++; $display("FAIL split_ar_count[%0d]: got %0d want %0d", t, got_ar_addr.size(), exp_ar_addr.size());
      end
      for (int i = 0; i < exp_ar_addr.size() && i < got_ar_addr.size(); i++) begin
        n_cmp++;
        if (got_ar_addr[i] !== exp_ar_addr[i] || got_ar_len[i] !== exp_ar_len[i]) begin
          n_bad++;
          $display("FAIL split_ar[%0d.%0d]: got %h/%0d want %h/%0d", t, i, got_ar_addr[i], got_ar_len[i], exp_ar_addr[i], exp_ar_len[i]);
        end
      end
      n_cmp++;
      if (got_data.size() != tn[t]) begin
        n_bad++; $display("FAIL split_beats[%0d]: got %0d want %0d", t, got_data.size(), tn[t]);
      end
      for (int i = 0; i < tn[t] && i < got_data.size(); i++) begin
        n_cmp++;
        if (got_data[i] !== exp_data[i] || got_last[i] !== (i == tn[t] - 1)) begin
          n_bad++;
          $display("FAIL split_beat[%0d.%0d]: got %h last %b want %h last %b", t, i, got_data[i], got_last[i], exp_data[i], (i == tn[t] - 1));
        end
      end
      n_cmp++;
      if (done_cnt != 1 || error !== 1'b0) begin
        n_bad++; $display("FAIL split_done[%0d]: got pulses %0d err %b want 1/0", t, done_cnt, error);
      end
    end
    rmode = 0;
  endtask

  task automatic test_slverr();
    bit to;
    err_beat = 3;
    build_model(32'h100, 8);
    run_xfer(32'h100, 8, 1'b0, to);
    n_cmp++;
    if (to || got_data.size() != 8) begin
      n_bad++; $display("FAIL slverr_beats: got %0d timeout %b want 8/0", got_data.size(), to);
    end
    for (int i = 0; i < 8 && i < got_data.size(); i++) begin
      n_cmp++;
      if (got_data[i] !== exp_data[i]) begin
        n_bad++; $display("FAIL slverr_data[%0d]: got %h want %h", i, got_data[i], exp_data[i]);
      end
    end
    n_cmp++;
    if (got_err.size() < 5 || got_err[3] !== 1'b0 || got_err[4] !== 1'b1) begin
      n_bad++; $display("FAIL slverr_rise: got beats %0d want ERROR 0 at beat 3, 1 at beat 4", got_err.size());
    end
    n_cmp++;
    if (error !== 1'b1 || done_cnt != 1) begin
      n_bad++; $display("FAIL slverr_sticky: got err %b pulses %0d want 1/1", error, done_cnt);
    end
    err_beat = -1;
    run_xfer(32'h200, 4, 1'b0, to);
    n_cmp++;
    if (to || got_err.size() != 4 || got_err[0] !== 1'b0 || error !== 1'b0) begin
      n_bad++; $display("FAIL slverr_clear: got err %b beats %0d want 0/4", error, got_err.size());
    end
  endtask

  task automatic test_backpressure();
    bit to;
    ar_delay = 3; rmode = 1;
    build_model(32'h2000, 40);
    run_xfer(32'h2000, 40, 1'b1, to);
    n_cmp++;
    if (to || done_cnt != 1) begin
      n_bad++; $display("FAIL bp_done: got pulses %0d timeout %b want 1/0", done_cnt, to);
    end
    n_cmp++;
    if (got_ar_addr.size() != 1 || got_ar_addr[0] !== 32'h2000 || got_ar_len[0] !== 8'd39) begin
      n_bad++; $display("FAIL bp_ar: got %0d ARs want one (2000,39)", got_ar_addr.size());
    end
    n_cmp++;
    if (arv_cycles != 4 || ar_unstable != 0) begin
      n_bad++; $display("FAIL bp_ar_hold: got valid cycles %0d unstable %0d want 4/0", arv_cycles, ar_unstable);
    end
    n_cmp++;
    if (rready_bad != 0 || valid_bad != 0) begin
      n_bad++; $display("FAIL bp_ready: got rready errs %0d valid errs %0d want 0/0", rready_bad, valid_bad);
    end
    n_cmp++;
    if (got_data.size() != 40) begin
      n_bad++; $display("FAIL bp_beats: got %0d want 40", got_data.size());
    end
    for (int i = 0; i < 40 && i < got_data.size(); i++) begin
      n_cmp++;
      if (got_data[i] !== exp_data[i]) begin
        n_bad++; $display("FAIL bp_data[%0d]: got %h want %h", i, got_data[i], exp_data[i]);
      end
    end
    ar_delay = 0; rmode = 0;
  endtask

  task automatic test_zero_len();
    bit to;
    run_xfer(32'h40, 0, 1'b0, to);
    n_cmp++;
    if (to || done_cnt != 1 || done_cyc - start_cyc != 2) begin
      n_bad++; $display("FAIL zero_done: got pulses %0d latency %0d want 1/2", done_cnt, done_cyc - start_cyc);
    end
    n_cmp++;
    if (arv_cycles != 0 || got_data.size() != 0 || busy_at_done !== 1'b1) begin
      n_bad++; $display("FAIL zero_bus: got arvalid cycles %0d beats %0d busy %b want 0/0/1", arv_cycles, got_data.size(), busy_at_done);
    end
  endtask

  task automatic test_mid_reset();
    bit hit, to;
    hit = 1'b0;
    clear_mon();
    @(negedge clk);
    start_addr = 32'h0001_0000; xfer_beats = XW'(300); init = 1'b1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk); #2;
      if (got_data.size() >= 20) begin hit = 1'b1; break; end
    end
    n_cmp++;
    if (!hit) begin n_bad++; $display("FAIL rst_mid_progress: got %0d beats want 20", got_data.size()); end
    rst = 1'b1; init = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({arvalid, rready, busy, dout_valid} !== 4'b0) begin
      n_bad++; $display("FAIL rst_mid_drop: got %b want 0000", {arvalid, rready, busy, dout_valid});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    build_model(32'h80, 5);
    run_xfer(32'h80, 5, 1'b0, to);
    n_cmp++;
    if (to || done_cnt != 1 || got_data.size() != 5 || got_data[0] !== exp_data[0] || got_data[4] !== exp_data[4]) begin
      n_bad++; $display("FAIL rst_recover: got beats %0d pulses %0d want 5/1", got_data.size(), done_cnt);
    end
  endtask

  task automatic test_rlast();
    bit to;
    logic want_err;
`ifdef AXI_RD_RLAST_CHECK_EN
    want_err = 1'b1;
`else
    want_err = 1'b0;
`endif
    rlast_beat = 5;
    run_xfer(32'h300, 8, 1'b0, to);
    n_cmp++;
    if (to || got_data.size() != 8 || error !== want_err) begin
      n_bad++; $display("FAIL rlast_check: got err %b beats %0d want %b/8", error, got_data.size(), want_err);
    end
    rlast_beat = -1;
  endtask

  initial begin
    test_reset();
    test_split();
    test_slverr();
    test_backpressure();
    test_zero_len();
    test_mid_reset();
    test_rlast();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
